stream_realigner: RTL and testbench
===================================

STREAM_REALIGNER -- requirements
Module: stream_realigner

Interface
REQ-001 SHALL have parameter LANE_W, default 64, bit width of one lane.
REQ-002 SHALL have parameter LANES, default 24, lanes per beat; legal range 2..63.
REQ-003 SHALL have parameter OFF_W, default 6, width of offset field; 2**OFF_W > LANES.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_tdata  in  LANES*LANE_W  input beat; lane i = bits [i*LANE_W +: LANE_W]; lane 0 is first in order.
REQ-007 SHALL have port s_tkeep  in  LANES  per-lane valid; used on last beat only, contiguous from lane 0.
REQ-008 SHALL have ports s_tvalid in 1, s_tready out 1, s_tlast in 1  AXI-Stream input handshake.
REQ-009 SHALL have port s_first  in  OFF_W  leading lanes to drop; sampled on first beat of packet only.
REQ-010 SHALL have port m_tdata  out  LANES*LANE_W  packed output beat.
REQ-011 SHALL have port m_tkeep  out  LANES  per-lane valid of output beat.
REQ-012 SHALL have ports m_tvalid out 1, m_tready in 1, m_tlast out 1  output handshake.

Function
REQ-013 SHALL drop s_first leading lanes of each packet and emit remaining lanes contiguously, order preserved, no gaps.
REQ-014 SHALL treat non-last input beats as all LANES lanes valid (s_tkeep ignored); last beat valid count = popcount(s_tkeep).
REQ-015 SHALL clamp s_first to the first beat's valid count; excess lanes are dropped, not carried to later beats.
REQ-016 SHALL hold a residual register of up to LANES-1 lanes plus count res_cnt (0..LANES-1).
REQ-017 SHALL per accepted beat with k contributed lanes: total = res_cnt + k; if total >= LANES, emit full beat (m_tkeep all ones); else emit nothing.
REQ-018 SHALL, if total >= LANES, set the new res_cnt = total - LANES, holding the unemitted lanes of the beat.
REQ-019 SHALL on accepted tlast beat: total <= LANES -> one beat, m_tkeep = total low ones, m_tlast=1; total > LANES -> full beat m_tlast=0, then FLUSH beat with residual, m_tlast=1.
REQ-020 SHALL emit a beat with m_tkeep=0, m_tlast=1 when a packet contributes zero lanes in total, preserving packet boundary.
REQ-021 SHALL set unused output lanes (m_tkeep bit 0) to zero data.
REQ-022 SHALL implement states IDLE (awaiting first beat), STREAM (mid-packet), FLUSH (residual pending); IDLE->STREAM on non-last first beat; any->IDLE after tlast beat fully emitted; STREAM/IDLE->FLUSH per REQ-019.
REQ-023 SHALL register outputs: output appears one cycle after the producing input handshake.
REQ-024 SHALL drive s_tready = (state != FLUSH) && (~m_tvalid || m_tready); sustain one beat/cycle when m_tready held high.
REQ-025 SHALL hold m_tdata/m_tkeep/m_tlast stable while m_tvalid && ~m_tready.
REQ-026 SHALL in FLUSH load residual beat when output register frees (same cycle as m_tready handshake), reset res_cnt=0, go IDLE.
REQ-027 SHALL start a new packet's first beat in the cycle after FLUSH completes; back-to-back packets need no idle cycle otherwise.

Reset
REQ-028 SHALL on rst_n=0 at a clock edge set m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, res_cnt=0, state=IDLE, discarding any partial packet.
REQ-029 SHALL drive s_tready=0 while rst_n=0.

Verification (LANES=4, LANE_W=8)
REQ-030 SHALL cover: s_first=0, beats {A0..A3},{A4..A7 last, keep=F}, m_tready=1 -> two full beats identical to input, second m_tlast=1, 1-cycle latency.
REQ-031 SHALL cover: s_first=1, beats {A0..A3},{A4..A7},{A8,A9 last keep=3} -> {A1..A4},{A5..A8},{A9 keep=1 last}.
REQ-032 SHALL cover: s_first=3, beats {A0..A3},{A4..A7 last keep=F} -> {A3..A6} then FLUSH {A7 keep=1 last}; s_tready=0 during FLUSH.
REQ-033 SHALL cover: single beat s_first=5, keep=F, last -> one beat m_tkeep=0, m_tlast=1.
REQ-034 SHALL cover: m_tready toggled randomly over 100 packets -> output stable while stalled, no lane lost or duplicated versus model.
REQ-035 SHALL cover: rst_n=0 asserted mid-packet with res_cnt=2 -> next cycle m_tvalid=0; next packet output with no stale lanes.

Source files
------------

// File: rtl/stream_realigner.sv
// Lane realigner: drops a per-packet number of leading lanes and repacks the
// remaining lanes into dense output beats, flushing any residual after tlast.
//
// state  | meaning
// IDLE   | waiting for the first beat of a packet (s_first is applied here)
// STREAM | mid-packet, residual lanes may be held
// FLUSH  | tlast seen, residual beat still to be emitted; input stalled
module stream_realigner #(
    parameter int LANE_W = 64,
    parameter int LANES  = 24,
    parameter int OFF_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*LANE_W-1:0] s_tdata,
    input  logic [LANES-1:0]        s_tkeep,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [OFF_W-1:0]        s_first,
    output logic [LANES*LANE_W-1:0] m_tdata,
    output logic [LANES-1:0]        m_tkeep,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast
);
    localparam int BEAT_W = LANES * LANE_W;
    localparam int CNT_W  = OFF_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   res_data, res_data_nxt;
    logic [CNT_W-1:0]    res_cnt, res_cnt_nxt;
    logic [BEAT_W-1:0]   m_tdata_nxt;
    logic [LANES-1:0]    m_tkeep_nxt;
    logic                m_tvalid_nxt, m_tlast_nxt;

    logic                out_free, accept;
    logic [CNT_W-1:0]    valid_cnt, drop_cnt, total;
    logic [BEAT_W-1:0]   in_masked;
    logic [2*BEAT_W-1:0] combined;

    function automatic logic [LANES-1:0] low_ones(input logic [CNT_W-1:0] n);
        logic [LANES-1:0] r;
        for (int i = 0; i < LANES; i++) r[i] = (i < int'(n));
        return r;
    endfunction

    assign out_free = !m_tvalid || m_tready;
    assign s_tready = rst_n && (state != FLUSH) && out_free;
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        valid_cnt = CNT_W'(LANES);
        if (s_tlast) begin
            valid_cnt = '0;
            for (int i = 0; i < LANES; i++) valid_cnt = valid_cnt + CNT_W'(s_tkeep[i]);
        end
        drop_cnt = '0;
        if (state == IDLE)
            drop_cnt = ({1'b0, s_first} > valid_cnt) ? valid_cnt : {1'b0, s_first};
        total = res_cnt + valid_cnt - drop_cnt;
    end

    // Residual sits in the low lanes (upper lanes kept zero), so the new lanes
    // can simply be shifted in above it; the upper half becomes the next residual.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            in_masked[i*LANE_W +: LANE_W] = (i < int'(valid_cnt)) ? s_tdata[i*LANE_W +: LANE_W]
                                                                  : {LANE_W{1'b0}};
        combined = (({{BEAT_W{1'b0}}, in_masked} >> (int'(drop_cnt) * LANE_W))
                    << (int'(res_cnt) * LANE_W)) | {{BEAT_W{1'b0}}, res_data};
    end

    always_comb begin
        state_nxt    = state;
        res_data_nxt = res_data;
        res_cnt_nxt  = res_cnt;
        m_tvalid_nxt = m_tvalid;
        m_tdata_nxt  = m_tdata;
        m_tkeep_nxt  = m_tkeep;
        m_tlast_nxt  = m_tlast;
        if (m_tvalid && m_tready) m_tvalid_nxt = 1'b0;

        if (state == FLUSH) begin
            if (out_free) begin
                m_tvalid_nxt = 1'b1;
                m_tdata_nxt  = res_data;
                m_tkeep_nxt  = low_ones(res_cnt);
                m_tlast_nxt  = 1'b1;
                res_data_nxt = '0;
                res_cnt_nxt  = '0;
                state_nxt    = IDLE;
            end
        end else if (accept) begin
            if (total >= CNT_W'(LANES) || s_tlast) begin
                m_tvalid_nxt = 1'b1;
                m_tdata_nxt  = combined[BEAT_W-1:0];
                m_tkeep_nxt  = (total >= CNT_W'(LANES)) ? {LANES{1'b1}} : low_ones(total);
                m_tlast_nxt  = s_tlast && (total <= CNT_W'(LANES));
            end
            if (total >= CNT_W'(LANES)) begin
                res_data_nxt = combined[2*BEAT_W-1:BEAT_W];
                res_cnt_nxt  = total - CNT_W'(LANES);
            end else begin
                res_data_nxt = combined[BEAT_W-1:0];
                res_cnt_nxt  = total;
            end
            if (!s_tlast) begin
                state_nxt = STREAM;
            end else if (total > CNT_W'(LANES)) begin
                state_nxt = FLUSH;
            end else begin
                state_nxt    = IDLE;
                res_data_nxt = '0;
                res_cnt_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            res_data <= '0;
            res_cnt  <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            state    <= state_nxt;
            res_data <= res_data_nxt;
            res_cnt  <= res_cnt_nxt;
            m_tvalid <= m_tvalid_nxt;
            m_tdata  <= m_tdata_nxt;
            m_tkeep  <= m_tkeep_nxt;
            m_tlast  <= m_tlast_nxt;
        end
    end

endmodule

// File: tb/tb_stream_realigner.sv
// Bench for stream_realigner with 4 lanes of 8 bits: directed packets with
// hand-written expectations plus randomized packets against a lane-list model.
module tb_stream_realigner;
    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int OFF_W  = 3;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [2:0]  s_first = '0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_rand = 0;
    int stall_breaks = 0;
    logic [7:0] seq = '0;

    beat_t in_q[$];
    int    in_first;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc[$];

    logic        prev_stall = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_keep;
    logic        held_last;

    stream_realigner #(.LANE_W(LANE_W), .LANES(LANES), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_first(s_first),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = (ready_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records handshaken beats and notices changes while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== held_data ||
                               m_tkeep !== held_keep || m_tlast !== held_last))
                stall_breaks <= stall_breaks + 1;
            if (m_tvalid && m_tready) begin
                obs_q.push_back('{m_tdata, m_tkeep, m_tlast});
                obs_cyc.push_back(cyc);
            end
            prev_stall <= m_tvalid && !m_tready;
            held_data  <= m_tdata;
            held_keep  <= m_tkeep;
            held_last  <= m_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void gen_pkt(input int nbeats, input int first, input logic [3:0] last_keep);
        beat_t b;
        in_q.delete();
        in_first = first;
        for (int j = 0; j < nbeats; j++) begin
            for (int i = 0; i < LANES; i++) begin
                b.data[i*8 +: 8] = seq;
                seq = seq + 8'd1;
            end
            b.last = (j == nbeats - 1);
            if (!b.last)              b.keep = 4'hF;
            else if (last_keep != 0)  b.keep = last_keep;
            else                      b.keep = 4'((1 << $urandom_range(1, 4)) - 1);
            in_q.push_back(b);
        end
    endfunction

    // Reference: flatten the packet into a lane list, drop the clamped prefix,
    // then chop into LANES-wide beats with tlast on the final chunk.
    function automatic void model_pkt();
        logic [7:0] lanes[$];
        int n;
        int drop;
        beat_t e;
        drop = 0;
        for (int b = 0; b < in_q.size(); b++) begin
            n = in_q[b].last ? $countones(in_q[b].keep) : LANES;
            for (int i = 0; i < n; i++) lanes.push_back(in_q[b].data[i*8 +: 8]);
            if (b == 0) drop = (in_first < n) ? in_first : n;
        end
        repeat (drop) void'(lanes.pop_front());
        if (lanes.size() == 0) begin
            e = '{32'h0, 4'h0, 1'b1};
            exp_q.push_back(e);
            return;
        end
        while (lanes.size() > 0) begin
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < LANES && lanes.size() > 0; i++) begin
                e.data[i*8 +: 8] = lanes.pop_front();
                e.keep[i] = 1'b1;
            end
            e.last = (lanes.size() == 0);
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_pkt(input int gap_pct, output int acc_cyc);
        int   budget;
        logic hs;
        acc_cyc = -1;
        for (int b = 0; b < in_q.size(); b++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = in_q[b].data;
            s_tkeep  = in_q[b].keep;
            s_tlast  = in_q[b].last;
            s_first  = 3'(in_first);
            hs = 1'b0;
            budget = 0;
            while (!hs && budget < 200) begin
                @(negedge clk);
                hs = s_tready;
                if (b == 0) acc_cyc = cyc;
                @(posedge clk);
                #1;
                budget++;
            end
            tests++;
            if (!hs) begin
                fails++;
                $display("FAIL send_timeout: s_tready low for %0d cycles, wanted handshake", budget);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL reset_m_tlast got %b want 0", m_tlast); end
        tests++; if (m_tkeep !== 4'h0) begin fails++; $display("FAIL reset_m_tkeep got %h want 0", m_tkeep); end
        tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL reset_m_tdata got %h want 0", m_tdata); end
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready got %b want 0", s_tready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        int acc;
        beat_t want[2];
        clear_q();
        seq = 8'h00;
        gen_pkt(2, 0, 4'hF);
        want[0] = '{32'h03020100, 4'hF, 1'b0};
        want[1] = '{32'h07060504, 4'hF, 1'b1};
        send_pkt(0, acc);
        drain();
        tests++;
        if (obs_q.size() !== 2) begin fails++; $display("FAIL pass_count got %0d want 2", obs_q.size()); end
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].data !== want[i].data || obs_q[i].keep !== want[i].keep || obs_q[i].last !== want[i].last) begin
                fails++;
                $display("FAIL pass_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data, obs_q[i].keep,
                         obs_q[i].last, want[i].data, want[i].keep, want[i].last);
            end
        end
        if (obs_cyc.size() > 0) begin
            tests++;
            if (obs_cyc[0] - acc !== 1) begin fails++; $display("FAIL pass_latency got %0d want 1", obs_cyc[0] - acc); end
        end
    endtask

    task automatic test_realign();
        int acc;
        beat_t want[3];
        clear_q();
        seq = 8'h00;
        gen_pkt(3, 1, 4'h3);
        want[0] = '{32'h04030201, 4'hF, 1'b0};
        want[1] = '{32'h08070605, 4'hF, 1'b0};
        want[2] = '{32'h00000009, 4'h1, 1'b1};
        send_pkt(0, acc);
        drain();
        tests++;
        if (obs_q.size() !== 3) begin fails++; $display("FAIL realign_count got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].data !== want[i].data || obs_q[i].keep !== want[i].keep || obs_q[i].last !== want[i].last) begin
                fails++;
                $display("FAIL realign_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data, obs_q[i].keep,
                         obs_q[i].last, want[i].data, want[i].keep, want[i].last);
            end
        end
    endtask

    task automatic test_flush();
        int acc;
        beat_t want[2];
        clear_q();
        seq = 8'h00;
        gen_pkt(2, 3, 4'hF);
        want[0] = '{32'h06050403, 4'hF, 1'b0};
        want[1] = '{32'h00000007, 4'h1, 1'b1};
        send_pkt(0, acc);
        @(negedge clk);
        tests++;
        if (s_tready !== 1'b0) begin fails++; $display("FAIL flush_s_tready got %b want 0", s_tready); end
        drain();
        tests++;
        if (obs_q.size() !== 2) begin fails++; $display("FAIL flush_count got %0d want 2", obs_q.size()); end
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].data !== want[i].data || obs_q[i].keep !== want[i].keep || obs_q[i].last !== want[i].last) begin
                fails++;
                $display("FAIL flush_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data, obs_q[i].keep,
                         obs_q[i].last, want[i].data, want[i].keep, want[i].last);
            end
        end
    endtask

    task automatic test_drop_all();
        int acc;
        clear_q();
        seq = 8'h40;
        gen_pkt(1, 5, 4'hF);
        send_pkt(0, acc);
        drain();
        tests++;
        if (obs_q.size() !== 1) begin
            fails++;
            $display("FAIL drop_all_count got %0d want 1", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].data !== 32'h0 || obs_q[0].keep !== 4'h0 || obs_q[0].last !== 1'b1) begin
                fails++;
                $display("FAIL drop_all_beat got %h/%h/%b want 00000000/0/1", obs_q[0].data, obs_q[0].keep, obs_q[0].last);
            end
        end
    endtask

    task automatic test_random_stall();
        int acc;
        int start_breaks;
        clear_q();
        start_breaks = stall_breaks;
        ready_rand = 1;
        for (int p = 0; p < 100; p++) begin
            gen_pkt($urandom_range(1, 4), $urandom_range(0, 7), 4'h0);
            model_pkt();
            send_pkt(30, acc);
        end
        drain();
        ready_rand = 0;
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL rand_count got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].keep !== exp_q[i].keep || obs_q[i].last !== exp_q[i].last) begin
                fails++;
                $display("FAIL rand_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data, obs_q[i].keep,
                         obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            end
        end
        tests++;
        if (stall_breaks - start_breaks !== 0) begin
            fails++;
            $display("FAIL rand_stall_stable got %0d changes while stalled want 0", stall_breaks - start_breaks);
        end
    endtask

    task automatic test_reset_mid_packet();
        int acc;
        clear_q();
        seq = 8'h10;
        gen_pkt(1, 2, 4'hF);
        in_q[0].last = 1'b0;
        send_pkt(0, acc);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (s_tready !== 1'b0) begin fails++; $display("FAIL midrst_s_tready got %b want 0", s_tready); end
        @(negedge clk);
        tests++;
        if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_m_tvalid got %b want 0", m_tvalid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        seq = 8'h20;
        gen_pkt(1, 0, 4'h3);
        send_pkt(0, acc);
        drain();
        tests++;
        if (obs_q.size() !== 1) begin
            fails++;
            $display("FAIL midrst_count got %0d want 1", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].data !== 32'h00002120 || obs_q[0].keep !== 4'h3 || obs_q[0].last !== 1'b1) begin
                fails++;
                $display("FAIL midrst_beat got %h/%h/%b want 00002120/3/1", obs_q[0].data, obs_q[0].keep, obs_q[0].last);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int t0;
        clear_q();
        t0 = cyc;
        for (int p = 0; p < 5; p++) begin
            gen_pkt(3, 0, 4'hF);
            model_pkt();
            send_pkt(0, acc);
        end
        tests++;
        if (cyc - t0 !== 15) begin fails++; $display("FAIL b2b_cycles got %0d want 15", cyc - t0); end
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].keep !== exp_q[i].keep || obs_q[i].last !== exp_q[i].last) begin
                fails++;
                $display("FAIL b2b_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data, obs_q[i].keep,
                         obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_realign();
        test_flush();
        test_drop_all();
        test_random_stall();
        test_reset_mid_packet();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
